// File: rtl/mem_bus_pkg.sv
// Shared types and defaults for the two-master memory bus controller.
package mem_bus_pkg;

  localparam int ADDR_W_DEF = 8;
  localparam int DATA_W_DEF = 8;

  typedef enum logic [1:0] {
    IDLE      = 2'd0,
    ACCESS    = 2'd1,
    READ_WAIT = 2'd2,
    RESP      = 2'd3
  } bus_state_t;

  typedef logic mst_idx_t;

  function automatic logic [1:0] idx_to_onehot(input mst_idx_t m);
    return m ? 2'b10 : 2'b01;
  endfunction

endpackage

// File: rtl/mem_arb2.sv
// Two-master arbiter: combinational one-hot grant, pointer advances on the advance strobe.
// Fixed priority (master 0) by default; round-robin when MEM_ARB_RR_EN is defined.
module mem_arb2 import mem_bus_pkg::*; (
  input  logic       clk,
  input  logic       rst,
  input  logic [1:0] req,
  input  logic       advance,
  output logic [1:0] grant
);

`ifdef MEM_ARB_RR_EN
  mst_idx_t last;

  // Reset value 1 makes master 0 the preferred winner of the first contest.
  always_ff @(posedge clk or posedge rst) begin
    if (rst)
      last <= 1'b1;
    else if (advance && (|req))
      last <= grant[1];
  end

  always_comb begin
    grant = 2'b00;
    if (req == 2'b11)
      grant = last ? 2'b01 : 2'b10;
    else
      grant = req;
  end
`else
  logic unused_fixed;
  assign unused_fixed = ^{clk, rst, advance};

  always_comb begin
    grant = 2'b00;
    if (req[0])
      grant = 2'b01;
    else if (req[1])
      grant = 2'b10;
  end
`endif

endmodule

// File: rtl/mem_bus_ctrl.sv
// Two-master single-port synchronous RAM controller: IDLE/ACCESS/READ_WAIT/RESP sequencer.
// Arbitration policy chosen at build time by MEM_ARB_RR_EN (see mem_arb2).
module mem_bus_ctrl import mem_bus_pkg::*; #(
  parameter int ADDR_W = ADDR_W_DEF,
  parameter int DATA_W = DATA_W_DEF
) (
  input  logic                clk,
  input  logic                rst,
  input  logic [1:0]          req,
  input  logic [1:0]          we,
  input  logic [2*ADDR_W-1:0] addr,
  input  logic [2*DATA_W-1:0] wdata,
  output logic [1:0]          gnt,
  output logic [1:0]          rvalid,
  output logic [DATA_W-1:0]   rdata,
  output logic                ram_we,
  output logic [ADDR_W-1:0]   ram_addr,
  output logic [DATA_W-1:0]   ram_din,
  input  logic [DATA_W-1:0]   ram_dout,
  output logic                busy
);

  bus_state_t state, state_nx;
  mst_idx_t   owner;
  mst_idx_t   win;
  logic       we_q;
  logic       advance;
  logic [1:0] arb_gnt;

  assign advance = (state == IDLE) && (|req);
  assign win     = arb_gnt[1];

  mem_arb2 u_arb (
    .clk     (clk),
    .rst     (rst),
    .req     (req),
    .advance (advance),
    .grant   (arb_gnt)
  );

  always_ff @(posedge clk or posedge rst) begin
    if (rst)
      state <= IDLE;
    else
      state <= state_nx;
  end

  always_comb begin
    state_nx = state;
    gnt      = 2'b00;
    rvalid   = 2'b00;
    ram_we   = 1'b0;
    busy     = (state != IDLE);
    case (state)
      IDLE:      if (|req) state_nx = ACCESS;
      ACCESS: begin
        gnt      = idx_to_onehot(owner);
        ram_we   = we_q;
        state_nx = we_q ? IDLE : READ_WAIT;
      end
      READ_WAIT: state_nx = RESP;
      RESP: begin
        rvalid   = idx_to_onehot(owner);
        state_nx = IDLE;
      end
      default:   state_nx = IDLE;
    endcase
  end

  // Request fields are captured only on the IDLE->ACCESS edge; RAM data only in READ_WAIT.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      owner    <= 1'b0;
      we_q     <= 1'b0;
      ram_addr <= '0;
      ram_din  <= '0;
      rdata    <= '0;
    end else begin
      if (advance) begin
        owner    <= win;
        we_q     <= win ? we[1] : we[0];
        ram_addr <= win ? addr[2*ADDR_W-1:ADDR_W] : addr[ADDR_W-1:0];
        ram_din  <= win ? wdata[2*DATA_W-1:DATA_W] : wdata[DATA_W-1:0];
      end
      if (state == READ_WAIT)
        rdata <= ram_dout;
    end
  end

endmodule

// File: tb/tb_mem_bus_ctrl.sv
// Directed scoreboard bench for mem_bus_ctrl with a behavioural synchronous RAM.
module tb_mem_bus_ctrl;

  localparam int AW = 8;
  localparam int DW = 8;

  logic            clk = 1'b0;
  logic            rst;
  logic [1:0]      req, we;
  logic [2*AW-1:0] addr;
  logic [2*DW-1:0] wdata;
  logic [1:0]      gnt, rvalid;
  logic [DW-1:0]   rdata;
  logic            ram_we;
  logic [AW-1:0]   ram_addr;
  logic [DW-1:0]   ram_din, ram_dout;
  logic            busy;

  int chk_cnt  = 0;
  int pass_cnt = 0;
  int fail_cnt = 0;

  int          gq[$];
  logic [15:0] wq[$];
  logic [8:0]  rq[$];

  logic [DW-1:0] mem [256];

  always #5 clk = ~clk;

  mem_bus_ctrl #(.ADDR_W(AW), .DATA_W(DW)) dut (
    .clk      (clk),
    .rst      (rst),
    .req      (req),
    .we       (we),
    .addr     (addr),
    .wdata    (wdata),
    .gnt      (gnt),
    .rvalid   (rvalid),
    .rdata    (rdata),
    .ram_we   (ram_we),
    .ram_addr (ram_addr),
    .ram_din  (ram_din),
    .ram_dout (ram_dout),
    .busy     (busy)
  );

  // RAM drives a poison pattern during writes in place of the undriven bus.
  always @(posedge clk) begin
    if (ram_we) begin
      mem[ram_addr] <= ram_din;
      ram_dout      <= 8'hEE;
    end else begin
      ram_dout <= mem[ram_addr];
    end
  end

  task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    chk_cnt++;
    assert (obs === exp) pass_cnt++;
    else begin
      fail_cnt++;
      $error("FAIL %s: observed 0x%0h expected 0x%0h", tag, obs, exp);
    end
  endtask

  always @(negedge clk) begin : mon
    int          m;
    logic [15:0] w;
    logic [8:0]  r;
    if (gnt != 2'b00) begin
      if (gq.size() == 0) check("gnt_unexpected", 32'(gnt), 0);
      else begin
        m = gq.pop_front();
        check("gnt_owner", 32'(gnt), (m != 0) ? 2 : 1);
      end
    end
    if (ram_we) begin
      if (wq.size() == 0) check("ram_we_unexpected", 32'(ram_we), 0);
      else begin
        w = wq.pop_front();
        check("ram_write", {16'h0, ram_addr, ram_din}, {16'h0, w});
      end
    end
    if (rvalid != 2'b00) begin
      if (rq.size() == 0) check("rvalid_unexpected", 32'(rvalid), 0);
      else begin
        r = rq.pop_front();
        check("rvalid_owner", 32'(rvalid), r[8] ? 2 : 1);
        check("rdata", 32'(rdata), 32'(r[7:0]));
      end
    end
  end

  task automatic wait_gnt(input int m);
    int n = 0;
    do begin @(posedge clk); #1; n++; end while (!gnt[m] && n < 20);
    check($sformatf("gnt%0d_seen", m), 32'(gnt[m]), 1);
  endtask

  task automatic wait_idle();
    int n = 0;
    do begin @(posedge clk); #1; n++; end while (busy && n < 20);
    check("idle_reached", 32'(busy), 0);
  endtask

  task automatic xact(input int m, input logic w, input logic [7:0] a,
                      input logic [7:0] d, input logic [7:0] rexp);
    int n;
    @(negedge clk);
    req[m] = 1'b1;
    we[m]  = w;
    addr[m*AW +: AW]  = a;
    wdata[m*DW +: DW] = d;
    gq.push_back(m);
    if (w) wq.push_back({a, d});
    else   rq.push_back({1'(m), rexp});
    wait_gnt(m);
    req[m] = 1'b0;
    if (!w) begin
      // gnt is one edge after sampling, rvalid two more.
      n = 0;
      do begin @(posedge clk); #1; n++; end while (!rvalid[m] && n < 10);
      check("rd_latency", 32'(n), 2);
    end
    wait_idle();
  endtask

  task automatic check_all_zero(input string tag);
    check({tag, "_gnt"},    32'(gnt), 0);
    check({tag, "_rvalid"}, 32'(rvalid), 0);
    check({tag, "_rdata"},  32'(rdata), 0);
    check({tag, "_ram_we"}, 32'(ram_we), 0);
    check({tag, "_addr"},   32'(ram_addr), 0);
    check({tag, "_din"},    32'(ram_din), 0);
    check({tag, "_busy"},   32'(busy), 0);
  endtask

  initial begin
    #100000;
    $display("FAIL watchdog: observed timeout expected completion");
    $fatal(1, "watchdog expired");
  end

  initial begin
    int n;
    for (int i = 0; i < 256; i++) mem[i] = '0;
    rst = 1'b1; req = '0; we = '0; addr = '0; wdata = '0;
    repeat (3) @(posedge clk);
    #1;
    check_all_zero("reset");
    @(negedge clk);
    rst = 1'b0;

    // Master 0 write then read back; outputs hold while idle.
    xact(0, 1'b1, 8'h10, 8'hA5, 8'h00);
    check("hold_addr", 32'(ram_addr), 32'h10);
    check("hold_din",  32'(ram_din),  32'hA5);
    check("idle_we",   32'(ram_we),   0);
    xact(0, 1'b0, 8'h10, 8'h00, 8'hA5);

    // Master 1 reads cleared location.
    xact(1, 1'b0, 8'h20, 8'h00, 8'h00);

    // Both masters held for four grants.
    @(negedge clk);
    req = 2'b11; we = 2'b11;
    addr = {8'h31, 8'h30}; wdata = {8'h22, 8'h11};
    for (int i = 0; i < 4; i++) begin
`ifdef MEM_ARB_RR_EN
      n = i % 2;
`else
      n = 0;
`endif
      gq.push_back(n);
      wq.push_back((n != 0) ? 16'h3122 : 16'h3011);
    end
    for (int k = 0; k < 4; k++) begin
      n = 0;
      do begin @(posedge clk); #1; n++; end while (gnt == 2'b00 && n < 20);
      check("both_gnt_seen", 32'(gnt != 2'b00), 1);
      if (k == 3) req = 2'b00;
      @(posedge clk); #1;
    end
    wait_idle();

    // Master 0 request arriving during master 1 READ_WAIT waits for IDLE.
    @(negedge clk);
    req[1] = 1'b1; we[1] = 1'b0; addr[15:8] = 8'h10;
    gq.push_back(1); rq.push_back({1'b1, 8'hA5});
    wait_gnt(1);
    req[1] = 1'b0;
    @(posedge clk); #1;
    check("busy_read_wait", 32'(busy), 1);
    req[0] = 1'b1; we[0] = 1'b0; addr[7:0] = 8'h20;
    gq.push_back(0); rq.push_back({1'b0, 8'h00});
    n = 0;
    do begin @(posedge clk); #1; n++; end while (!gnt[0] && n < 20);
    check("late_gnt0_delay", 32'(n), 3);
    req[0] = 1'b0;
    wait_idle();

    // Reset during READ_WAIT abandons the read.
    @(negedge clk);
    req[0] = 1'b1; we[0] = 1'b0; addr[7:0] = 8'h10;
    gq.push_back(0);
    wait_gnt(0);
    req[0] = 1'b0;
    @(posedge clk); #1;
    check("rst_in_read_wait", 32'(busy), 1);
    rst = 1'b1;
    #1;
    check_all_zero("midrst");
    repeat (2) @(negedge clk);
    rst = 1'b0;
    repeat (6) @(posedge clk);
    #1;
    check("post_rst_idle", 32'(busy), 0);
    xact(0, 1'b0, 8'h10, 8'h00, 8'hA5);

    // Top-of-range address; write cycle must not disturb rdata.
    xact(1, 1'b1, 8'hFF, 8'h3C, 8'h00);
    check("rdata_hold_after_wr", 32'(rdata), 32'hA5);
    xact(1, 1'b0, 8'hFF, 8'h00, 8'h3C);

    repeat (3) @(posedge clk);
    #1;
    check("gq_empty", 32'(gq.size()), 0);
    check("wq_empty", 32'(wq.size()), 0);
    check("rq_empty", 32'(rq.size()), 0);

    $display("%0d/%0d checks passed", pass_cnt, chk_cnt);
    $finish;
  end

endmodule
